sirv_otp_rd_ctrl: RTL and testbench
===================================

Name: sirv_otp_rd_ctrl

Overview:
- Downstream of the OTP top wrapper. Consumes the single ICB command stream that the wrapper's arbitrated ports produce.
- Drives the OTP hard-macro read pins with programmable setup, strobe and hold timing.
- Returns captured 32-bit words as ICB responses.
- Read-only: writes are accepted and answered with an error response, with no macro access.

Parameters:
- OTP_AW, 13, OTP word-address width (8K words, 32 KB).
- T_SETUP, 1, cycles address and CE are stable before the read strobe (min 1).
- T_RD, 4, cycles the read strobe is high (min 1).
- T_HOLD, 1, cycles CE and address are held after the strobe falls (min 1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- icb_cmd_valid  input  1  command valid
- icb_cmd_ready  output  1  command ready
- icb_cmd_addr  input  32  byte address
- icb_cmd_read  input  1  1=read, 0=write
- icb_cmd_wdata  input  32  write data (ignored)
- icb_rsp_valid  output  1  response valid
- icb_rsp_ready  input  1  response ready
- icb_rsp_rdata  output  32  read data
- icb_rsp_err  output  1  error (write attempt)
- otp_ce  output  1  macro chip enable
- otp_rd  output  1  macro read strobe
- otp_a  output  OTP_AW  macro word address
- otp_q  input  32  macro read data

Behaviour:
- One clock (clk); asynchronous active-low reset rst_n.
- Reset values: icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, otp_ce=0, otp_rd=0, otp_a=0, FSM=IDLE, counter=0.
- FSM states: IDLE, SETUP, READ, HOLD, RSP. A single down-counter is loaded on each timed-state entry.
- icb_cmd_ready=1 only in IDLE (combinational from state). A handshake is valid&ready.
- IDLE, read handshake:
  - Latch otp_a = icb_cmd_addr[OTP_AW+1:2]. Address bits [1:0] and bits above OTP_AW+1 are ignored; the upstream decoder guarantees range.
  - otp_ce=1, go to SETUP for T_SETUP cycles.
- SETUP -> READ: otp_rd=1 for T_RD cycles.
  - otp_q is sampled into the rdata register on the last READ cycle.
- READ -> HOLD: otp_rd=0, otp_ce stays 1 for T_HOLD cycles.
- HOLD -> RSP: otp_ce=0, icb_rsp_valid=1, icb_rsp_err=0.
- IDLE, write handshake: go straight to RSP next cycle with err=1 and rdata=0. otp_ce and otp_rd stay 0.
- RSP:
  - icb_rsp_valid, rdata and err are held stable until icb_rsp_ready=1.
  - On the rsp handshake: rsp_valid=0, go to IDLE.
  - No new command is accepted in the same cycle, so one transaction is outstanding at most.
- Read latency: with the cmd handshake in cycle 0, icb_rsp_valid rises in cycle T_SETUP+T_RD+T_HOLD+1 (7 with defaults).
- Write latency: 1 cycle.
- otp_a changes only in IDLE on a handshake. It is stable throughout SETUP, READ and HOLD.
- Asserting rst_n low mid-access forces all outputs to their reset values immediately, including otp_rd low. The transaction is lost and no response is issued.
- icb_cmd_valid dropping without a handshake has no effect.

Optional Feature:
- Macro: OTP_RD_BUF_EN.
- Defined: adds a one-entry last-word buffer (valid bit, OTP_AW tag, 32-bit data).
  - Filled on every macro read capture; valid is cleared by reset only.
  - A read hit (buffer valid and tag == word address) goes IDLE -> RSP next cycle with the buffered data and no macro access (1-cycle latency).
  - A read miss follows the full read sequence.
  - Writes never touch the buffer.
- Undefined: there is no buffer, and every read performs a macro access.

Test Plan:
- Reset, then a read at addr 0x0000_0010 with otp_q=0xDEADBEEF:
  - otp_a=4; otp_rd high in cycles 2-5 only.
  - rsp_valid in cycle 7 with rdata=0xDEADBEEF, err=0.
- Write at addr 0x20 with wdata 0x12345678:
  - rsp in cycle 1 with err=1, rdata=0.
  - otp_ce and otp_rd never assert.
- Read with icb_rsp_ready held low for 5 cycles after rsp_valid:
  - rdata and err stay stable; cmd_ready=0 throughout.
  - A second cmd is accepted only in the cycle after the rsp handshake.
- rst_n asserted during READ:
  - otp_rd, otp_ce and rsp_valid are 0 immediately.
  - After release, a new read at addr 0x4 completes normally with otp_a=1.
- Address 0xFFFF_FFFC:
  - otp_a=0x1FFF, with the upper bits dropped.
- With OTP_RD_BUF_EN, reads at 0x40 then 0x40:
  - Second rsp arrives in cycle 1 with identical data and no otp_ce pulse.
  - A subsequent read at 0x44 takes 7 cycles.

Source files
------------

// File: rtl/sirv_otp_rd_ctrl.sv
// sirv_otp_rd_ctrl: OTP hard-macro read controller behind the OTP top wrapper.
// It accepts one ICB command at a time. A read drives CE, address and the read strobe with
// programmable setup, strobe and hold timing, then returns the captured word.
// A write gets an error response and never touches the macro.
// Optional feature macro: OTP_RD_BUF_EN. It adds a one-entry last-word buffer, so a repeated
// read of the same word completes without a macro access.
module sirv_otp_rd_ctrl #(
  parameter int OTP_AW  = 13,
  parameter int T_SETUP = 1,
  parameter int T_RD    = 4,
  parameter int T_HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [31:0]       icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_wdata,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [31:0]       icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              otp_ce,
  output logic              otp_rd,
  output logic [OTP_AW-1:0] otp_a,
  input  logic [31:0]       otp_q
);

  // The single down-counter holds (cycles - 1) for the current timed state.
  localparam int TMAX_SR = (T_SETUP > T_RD) ? T_SETUP : T_RD;
  localparam int TMAX    = (TMAX_SR > T_HOLD) ? TMAX_SR : T_HOLD;
  localparam int CNT_W   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_RD    = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, READ, HOLD, RSP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ce_q, ce_d;
  logic              rd_q, rd_d;
  logic [OTP_AW-1:0] a_q, a_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [OTP_AW-1:0] cmd_word;
  logic              cmd_hs;
  logic              capture;
  logic              buf_hit;
  logic [31:0]       buf_rdata;

  // Upper address bits, byte-lane bits and write data carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{icb_cmd_wdata, icb_cmd_addr[31:OTP_AW+2], icb_cmd_addr[1:0]};

  assign cmd_word      = icb_cmd_addr[OTP_AW+1:2];
  assign icb_cmd_ready = (state_q == IDLE);
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
  assign capture       = (state_q == READ) && (cnt_q == '0);

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;
  assign otp_ce        = ce_q;
  assign otp_rd        = rd_q;
  assign otp_a         = a_q;

`ifdef OTP_RD_BUF_EN
  logic              buf_vld_q;
  logic [OTP_AW-1:0] buf_tag_q;
  logic [31:0]       buf_data_q;

  assign buf_hit   = buf_vld_q && (buf_tag_q == cmd_word);
  assign buf_rdata = buf_data_q;

  // Buffer valid bit: set by the first macro capture, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q <= 1'b0;
    end else if (capture) begin
      buf_vld_q <= 1'b1;
    end
  end

  // Buffer tag and data: refreshed on every macro capture. They are qualified by valid, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_tag_q  <= a_q;
      buf_data_q <= otp_q;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = 32'h0;
`endif

  // State, counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      rd_q        <= 1'b0;
      a_q         <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic and next output values. Every register holds its value by default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ce_d        = ce_q;
    rd_d        = rd_q;
    a_d         = a_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (!icb_cmd_read) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = 32'h0;
          end else if (buf_hit) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b0;
            rdata_d     = buf_rdata;
          end else begin
            state_d = SETUP;
            cnt_d   = LD_SETUP;
            ce_d    = 1'b1;
            a_d     = cmd_word;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = READ;
          cnt_d   = LD_RD;
          rd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = LD_HOLD;
          rd_d    = 1'b0;
          rdata_d = otp_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d     = RSP;
          ce_d        = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RSP: begin
        if (icb_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sirv_otp_rd_ctrl.sv
// Directed testbench for sirv_otp_rd_ctrl using the default timing parameters.
module tb_sirv_otp_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        otp_ce, otp_rd;
  logic [12:0] otp_a;
  logic [31:0] otp_q;

  int n_cmp = 0;
  int n_bad = 0;

  sirv_otp_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
    .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(rsp_rdata),
    .icb_rsp_err(rsp_err),
    .otp_ce(otp_ce), .otp_rd(otp_rd), .otp_a(otp_a), .otp_q(otp_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one command in cycle 0 and follow it until rsp_valid, recording per-cycle pin activity.
  task automatic do_txn(input logic [31:0] addr, input logic rd, input logic [31:0] q,
                        output int lat, output logic [15:0] rdm, output logic [15:0] cem,
                        output logic [12:0] a_seen);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = 32'h12345678; otp_q = q;
    chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    tick;
    cmd_valid = 1'b0;
    lat = 0; rdm = '0; cem = '0; a_seen = '0;
    for (int c = 1; c < 16; c++) begin
      rdm[c] = otp_rd;
      cem[c] = otp_ce;
      if (otp_ce) a_seen = otp_a;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      tick;
    end
  endtask

  task automatic rsp_hs;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_dropped", {31'h0, rsp_valid}, 32'h0);
    chk("back_to_idle", {31'h0, cmd_ready}, 32'h1);
  endtask

  int          lat;
  logic [15:0] rdm, cem;
  logic [12:0] a_seen;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; otp_q = '0;
    tick; tick;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_ce_rd", {30'h0, otp_ce, otp_rd}, 32'h0);
    chk("rst_a", {19'h0, otp_a}, 32'h0);
    rst_n = 1'b1;
    tick;

    // Basic read: strobe in cycles 2-5, CE in cycles 1-6, response in cycle 7.
    do_txn(32'h0000_0010, 1'b1, 32'hDEADBEEF, lat, rdm, cem, a_seen);
    chk("rd_latency", lat, 7);
    chk("rd_strobe_cycles", {16'h0, rdm}, 32'h0000_003C);
    chk("rd_ce_cycles", {16'h0, cem}, 32'h0000_007E);
    chk("rd_addr", {19'h0, a_seen}, 32'h4);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", {31'h0, rsp_err}, 32'h0);
    rsp_hs();

    // Write: error response in cycle 1, macro untouched.
    do_txn(32'h0000_0020, 1'b0, 32'h5555AAAA, lat, rdm, cem, a_seen);
    chk("wr_latency", lat, 1);
    chk("wr_err", {31'h0, rsp_err}, 32'h1);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_no_pins", {16'h0, rdm | cem}, 32'h0);
    rsp_hs();

    // Response back-pressure with a second command waiting.
    do_txn(32'h0000_0008, 1'b1, 32'hCAFEF00D, lat, rdm, cem, a_seen);
    chk("bp_latency", lat, 7);
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0000_000C; otp_q = 32'h0BADF00D;
    chk("bp_ready_rsp", {31'h0, cmd_ready}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_hold_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("bp_hold_err", {31'h0, rsp_err}, 32'h0);
      chk("bp_hold_ready", {31'h0, cmd_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    chk("bp_no_accept_hs", {31'h0, cmd_ready}, 32'h0);
    tick;
    rsp_ready = 1'b0;
    chk("bp_valid_drop", {31'h0, rsp_valid}, 32'h0);
    do_txn(32'h0000_000C, 1'b1, 32'h0BADF00D, lat, rdm, cem, a_seen);
    chk("bp2_latency", lat, 7);
    chk("bp2_addr", {19'h0, a_seen}, 32'h3);
    chk("bp2_rdata", rsp_rdata, 32'h0BADF00D);
    rsp_hs();

    // Reset during READ drops everything at once.
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0000_0100; otp_q = 32'h11111111;
    tick;
    cmd_valid = 1'b0;
    tick; tick;
    chk("mid_rd_active", {30'h0, otp_ce, otp_rd}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pins", {29'h0, otp_ce, otp_rd, rsp_valid}, 32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    do_txn(32'h0000_0004, 1'b1, 32'h600DCAFE, lat, rdm, cem, a_seen);
    chk("post_rst_latency", lat, 7);
    chk("post_rst_addr", {19'h0, a_seen}, 32'h1);
    chk("post_rst_rdata", rsp_rdata, 32'h600DCAFE);
    rsp_hs();

    // Top of the address space: upper bits dropped.
    do_txn(32'hFFFF_FFFC, 1'b1, 32'hA5A5A5A5, lat, rdm, cem, a_seen);
    chk("top_addr", {19'h0, a_seen}, 32'h1FFF);
    chk("top_rdata", rsp_rdata, 32'hA5A5A5A5);
    rsp_hs();

    // Repeated read of one word, then a neighbour.
    do_txn(32'h0000_0040, 1'b1, 32'h01234567, lat, rdm, cem, a_seen);
    chk("buf1_latency", lat, 7);
    chk("buf1_rdata", rsp_rdata, 32'h01234567);
    rsp_hs();
    do_txn(32'h0000_0040, 1'b1, 32'h89ABCDEF, lat, rdm, cem, a_seen);
`ifdef OTP_RD_BUF_EN
    chk("buf2_hit_latency", lat, 1);
    chk("buf2_hit_rdata", rsp_rdata, 32'h01234567);
    chk("buf2_no_ce", {16'h0, cem}, 32'h0);
`else
    chk("buf2_latency", lat, 7);
    chk("buf2_rdata", rsp_rdata, 32'h89ABCDEF);
`endif
    rsp_hs();
    do_txn(32'h0000_0044, 1'b1, 32'h13579BDF, lat, rdm, cem, a_seen);
    chk("buf3_latency", lat, 7);
    chk("buf3_addr", {19'h0, a_seen}, 32'h11);
    chk("buf3_rdata", rsp_rdata, 32'h13579BDF);
    rsp_hs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
